ct_sysio_flush_arb: RTL and testbench

//  L2 cache flush arbiter/sequencer in the sysio domain. Shares the single sysio->L2C flush

---
 rtl/ct_sysio_flush_arb.sv | 110 +++++++++++
 tb/tb_ct_sysio_flush_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ct_sysio_flush_arb.sv
// L2C flush arbiter for the sysio domain: round-robin sharing of the
// single sysio->L2C flush handshake among NUM_REQ 4-phase requesters.
module ct_sysio_flush_arb #(
  parameter int NUM_REQ = 2,
  parameter int GNT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TO_W    = 16
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  input  logic               axim_clk_en,
  input  logic [NUM_REQ-1:0] flush_req,
  output logic [NUM_REQ-1:0] flush_ack,
  input  logic               l2c_sysio_flush_done,
  input  logic               l2c_sysio_flush_idle,
  output logic               sysio_l2c_flush_req,
  input  logic [TO_W-1:0]    flush_to_limit,
  input  logic               flush_to_clr,
  output logic               flush_busy,
  output logic [GNT_W-1:0]   flush_gnt_id,
  output logic               flush_to_err,
  output logic               flush_no_op
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state;
  logic [GNT_W-1:0] rr_ptr;
  logic [TO_W-1:0]  cnt;
  logic [TO_W:0]    cnt_p1;
  logic [GNT_W-1:0] pick;
  logic             hit;
  logic [GNT_W-1:0] ptr_nxt;
  logic             to_hit;
  int               j;

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    pick = rr_ptr;
    hit  = 1'b0;
    j    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!hit && flush_req[j]) begin
        hit  = 1'b1;
        pick = GNT_W'(j);
      end
    end
  end

  assign ptr_nxt = (int'(flush_gnt_id) == NUM_REQ - 1) ?
                   '0 : flush_gnt_id + 1'b1;

  // extra bit keeps a saturated counter from matching after wrap
  assign cnt_p1 = {1'b0, cnt} + 1'b1;
  assign to_hit = (flush_to_limit != '0) &&
                  (cnt_p1 == {1'b0, flush_to_limit});

  assign flush_busy = (state != IDLE);

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      cnt                 <= '0;
      flush_ack           <= '0;
      sysio_l2c_flush_req <= 1'b0;
      flush_gnt_id        <= '0;
      flush_to_err        <= 1'b0;
      flush_no_op         <= 1'b0;
    end else if (axim_clk_en) begin
      flush_no_op <= (state == IDLE) && l2c_sysio_flush_idle &&
                     !(|flush_req);
      if (flush_to_clr) flush_to_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            flush_gnt_id        <= pick;
            sysio_l2c_flush_req <= 1'b1;
            cnt                 <= '0;
            state               <= FLUSH;
          end
        end
        FLUSH: begin
          if (l2c_sysio_flush_done) begin
            sysio_l2c_flush_req <= 1'b0;
            flush_ack <= NUM_REQ'(1) << flush_gnt_id;
            state     <= ACK;
          end else begin
            if (cnt != '1) cnt <= cnt_p1[TO_W-1:0];
            if (to_hit) flush_to_err <= 1'b1;
          end
        end
        ACK: begin
          if (!flush_req[flush_gnt_id] && !l2c_sysio_flush_done) begin
            flush_ack <= '0;
            rr_ptr    <= ptr_nxt;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ct_sysio_flush_arb.sv
// Directed bench for ct_sysio_flush_arb: grant order, latency,
// clock enable, watchdog, async reset and early request drop.
module tb_ct_sysio_flush_arb;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  req;
  logic [1:0]  ack;
  logic        done;
  logic        l2_idle;
  logic        l2_req;
  logic [15:0] limit;
  logic        clr;
  logic        busy;
  logic [0:0]  gnt;
  logic        err;
  logic        no_op;

  int checks   = 0;
  int failures = 0;
  int order[4] = '{1, 0, 1, 0};

  ct_sysio_flush_arb #(.NUM_REQ(2), .GNT_W(1), .TO_W(16)) dut (
    .forever_cpuclk       (clk),
    .cpurst_b             (rst_n),
    .axim_clk_en          (en),
    .flush_req            (req),
    .flush_ack            (ack),
    .l2c_sysio_flush_done (done),
    .l2c_sysio_flush_idle (l2_idle),
    .sysio_l2c_flush_req  (l2_req),
    .flush_to_limit       (limit),
    .flush_to_clr         (clr),
    .flush_busy           (busy),
    .flush_gnt_id         (gnt),
    .flush_to_err         (err),
    .flush_no_op          (no_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req = 2'b00; done = 1'b0;
    l2_idle = 1'b1; limit = 16'd0; clr = 1'b0;
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_l2req", l2_req, 0);
    chk("rst_ack", ack, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_err", err, 0);
    chk("rst_noop", no_op, 0);
    rst_n = 1'b1;
    step(1);
    chk("idle_noop", no_op, 1);

    // single request, done after 5 cycles
    req = 2'b01;
    step(1);
    chk("t1_l2req", l2_req, 1);
    chk("t1_busy", busy, 1);
    chk("t1_gnt", gnt, 0);
    step(4);
    chk("t1_wait_ack", ack, 0);
    chk("t1_noop", no_op, 0);
    done = 1'b1;
    step(1);
    chk("t1_ack", ack, 2'b01);
    chk("t1_l2req_lo", l2_req, 0);
    req = 2'b00;
    step(1);
    chk("t1_ack_hold_done", ack, 2'b01);
    done = 1'b0;
    step(1);
    chk("t1_ack_lo", ack, 0);
    chk("t1_busy_lo", busy, 0);

    // round robin with both requesting; rr_ptr is now 1
    for (int k = 0; k < 4; k++) begin
      req = 2'b11;
      step(1);
      chk("t2_gnt", gnt, order[k]);
      chk("t2_l2req", l2_req, 1);
      step(2);
      done = 1'b1;
      step(1);
      chk("t2_ack", ack, 32'(2'b01 << order[k]));
      req[order[k]] = 1'b0;
      done = 1'b0;
      step(1);
      chk("t2_ack_lo", ack, 0);
      chk("t2_busy_lo", busy, 0);
    end
    req = 2'b00;
    step(1);

    // clock enable 1:3, rr_ptr = 1 so req 0 still wins alone
    req = 2'b01;
    en = 1'b0;
    step(2);
    chk("t3_hold_busy", busy, 0);
    en = 1'b1;
    step(1);
    chk("t3_busy", busy, 1);
    chk("t3_gnt", gnt, 0);
    done = 1'b1;
    en = 1'b0;
    step(2);
    chk("t3_hold_ack", ack, 0);
    en = 1'b1;
    step(1);
    chk("t3_ack", ack, 2'b01);
    req = 2'b00; done = 1'b0; en = 1'b0;
    step(2);
    chk("t3_hold_ack2", ack, 2'b01);
    en = 1'b1;
    step(1);
    chk("t3_ack_lo", ack, 0);
    chk("t3_busy_lo", busy, 0);

    // watchdog at 10, clear coincident with set loses
    limit = 16'd10;
    req = 2'b10;
    step(1);
    chk("t4_gnt", gnt, 1);
    step(9);
    chk("t4_err_pre", err, 0);
    clr = 1'b1;
    step(1);
    chk("t4_err_set", err, 1);
    chk("t4_l2req", l2_req, 1);
    step(1);
    chk("t4_err_clr", err, 0);
    clr = 1'b0;
    done = 1'b1;
    step(1);
    chk("t4_ack", ack, 2'b10);
    req = 2'b00; done = 1'b0;
    step(1);
    chk("t4_busy_lo", busy, 0);

    // watchdog disabled
    limit = 16'd0;
    req = 2'b01;
    step(1);
    chk("t4b_gnt", gnt, 0);
    step(20);
    chk("t4b_err", err, 0);
    done = 1'b1;
    step(1);
    req = 2'b00; done = 1'b0;
    step(1);
    chk("t4b_busy_lo", busy, 0);

    // reset mid-flush with error set; rr_ptr = 1
    limit = 16'd3;
    req = 2'b10;
    step(4);
    chk("t5_err", err, 1);
    chk("t5_l2req", l2_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_l2req_async", l2_req, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_err_async", err, 0);
    chk("t5_ack_async", ack, 0);
    req = 2'b00; limit = 16'd0;
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("t5_busy_after", busy, 0);
    chk("t5_l2req_after", l2_req, 0);
    chk("t5_noop", no_op, 1);

    // early drop of request 1 during FLUSH; rr_ptr = 0 after reset
    req = 2'b10;
    step(2);
    chk("t6_gnt", gnt, 1);
    req = 2'b00;
    step(2);
    chk("t6_l2req", l2_req, 1);
    chk("t6_busy", busy, 1);
    done = 1'b1;
    step(1);
    chk("t6_ack", ack, 2'b10);
    done = 1'b0;
    step(1);
    chk("t6_ack_lo", ack, 0);
    chk("t6_busy_lo", busy, 0);

    // done while idle is ignored
    done = 1'b1;
    step(2);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_ack", ack, 0);
    done = 1'b0;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
